// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO decoupling ALU results from register-file writeback
// Optional statistics counters are built when ALU_RESULT_STATS_EN is defined.
module alu_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_zero,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic [3:0]  out_op,
    output logic [4:0]  out_rd,
    output logic [15:0] stat_zero_cnt,
    output logic [15:0] stat_total_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_result_q [DEPTH];
    logic          mem_zero_q   [DEPTH];
    logic [3:0]    mem_op_q     [DEPTH];
    logic [4:0]    mem_rd_q     [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, push_kept;

    // Readiness is derived from registered count only, so a pop never opens a full buffer in the same cycle.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign push_kept = push & ~flush;

    assign out_result = mem_result_q[rd_ptr_q];
    assign out_zero   = mem_zero_q[rd_ptr_q];
    assign out_op     = mem_op_q[rd_ptr_q];
    assign out_rd     = mem_rd_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result_q[i] <= '0;
                mem_zero_q[i]   <= 1'b0;
                mem_op_q[i]     <= '0;
                mem_rd_q[i]     <= '0;
            end
        end else if (push_kept) begin
            mem_result_q[wr_ptr_q] <= in_result;
            mem_zero_q[wr_ptr_q]   <= in_zero;
            mem_op_q[wr_ptr_q]     <= in_op;
            mem_rd_q[wr_ptr_q]     <= in_rd;
        end
    end

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] stat_zero_q, stat_zero_d;
    logic [15:0] stat_total_q, stat_total_d;

    // Saturating counters; a push discarded by flush is not counted.
    always_comb begin
        stat_zero_d  = stat_zero_q;
        stat_total_d = stat_total_q;
        if (push_kept) begin
            if (stat_total_q != 16'hFFFF) stat_total_d = stat_total_q + 16'd1;
            if (in_zero && stat_zero_q != 16'hFFFF) stat_zero_d = stat_zero_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_zero_q  <= '0;
            stat_total_q <= '0;
        end else begin
            stat_zero_q  <= stat_zero_d;
            stat_total_q <= stat_total_d;
        end
    end

    assign stat_zero_cnt  = stat_zero_q;
    assign stat_total_cnt = stat_total_q;
`else
    assign stat_zero_cnt  = 16'h0000;
    assign stat_total_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_zero, out_valid, out_ready, out_zero;
    logic [31:0] in_result, out_result;
    logic [3:0]  in_op, out_op;
    logic [4:0]  in_rd, out_rd;
    logic [15:0] stat_zero_cnt, stat_total_cnt;

    int errors = 0;
    int checks = 0;

    alu_result_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_op(in_op), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_op(out_op), .out_rd(out_rd),
        .stat_zero_cnt(stat_zero_cnt), .stat_total_cnt(stat_total_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set here apply to the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic z,
                         input logic [3:0] op, input logic [4:0] rd);
        in_valid  = v;
        in_result = r;
        in_zero   = z;
        in_op     = op;
        in_rd     = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_result, out_zero, out_op, out_rd} !== 42'h0) begin errors++;
            $display("FAIL reset_fields got=%h/%b/%h/%0d exp=0", out_result, out_zero, out_op, out_rd); end
        checks++; if ({stat_zero_cnt, stat_total_cnt} !== 32'h0) begin errors++;
            $display("FAIL reset_stats got=%h/%h exp=0", stat_zero_cnt, stat_total_cnt); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_00F0, 1'b0, 4'b1010, 5'd5);
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if ({out_result, out_zero, out_op, out_rd} !== {32'h0000_00F0, 1'b0, 4'b1010, 5'd5}) begin errors++;
            $display("FAIL single_fields got=%h/%b/%b/%0d exp=000000f0/0/1010/5", out_result, out_zero, out_op, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'hA000_0000 + k, (k == 2), 4'b1011, 5'(k));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_rd !== 5'(k) || out_result !== 32'hA000_0000 + k || out_zero !== (k == 2)) begin
                errors++; $display("FAIL full_drain_%0d got=v%b rd%0d %h z%b exp=v1 rd%0d", k, out_valid, out_rd, out_result, out_zero, k); end
            checks++; if (in_ready !== (k != 1)) begin errors++;
                $display("FAIL full_ready_%0d got=%b exp=%b", k, in_ready, (k != 1)); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hB000_0000 + k, 1'b0, 4'b1100, 5'(10 + k));
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'hB000_0000 + 2 + k, 1'b0, 4'b1100, 5'(12 + k));
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_rd !== 5'(10 + k) || out_result !== 32'hB000_0000 + k) begin
                errors++; $display("FAIL b2b_%0d got=v%b r%b rd%0d %h exp=v1 r1 rd%0d", k, out_valid, in_ready, out_rd, out_result, 10 + k); end
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (out_valid !== 1'b1 || out_rd !== 5'(20 + k)) begin errors++;
                $display("FAIL b2b_tail_%0d got=v%b rd%0d exp=v1 rd%0d", k, out_valid, out_rd, 20 + k); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 32'hC000_0000 + k, 1'b0, 4'b0001, 5'(k));
            step();
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 4'b1111, 5'd9);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_state got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        drive(1'b1, 32'h0000_0007, 1'b0, 4'b1010, 5'd7);
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_result !== 32'h7) begin errors++;
            $display("FAIL flush_next got=v%b rd%0d %h exp=v1 rd7 00000007", out_valid, out_rd, out_result); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_stats();
        rst = 1'b1; #2; rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0, (k < 3), 4'b1010, 5'(k));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
`ifdef ALU_RESULT_STATS_EN
        checks++; if (stat_zero_cnt !== 16'd3 || stat_total_cnt !== 16'd5) begin errors++;
            $display("FAIL stats_count got=%0d/%0d exp=3/5", stat_zero_cnt, stat_total_cnt); end
        force dut.stat_total_q = 16'hFFFE;
        #1;
        release dut.stat_total_q;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h1, 1'b0, 4'b1011, 5'(k));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        checks++; if (stat_total_cnt !== 16'hFFFF || stat_zero_cnt !== 16'd3) begin errors++;
            $display("FAIL stats_saturate got=%h/%h exp=0003/ffff", stat_zero_cnt, stat_total_cnt); end
`else
        checks++; if (stat_zero_cnt !== 16'h0 || stat_total_cnt !== 16'h0) begin errors++;
            $display("FAIL stats_tied got=%h/%h exp=0/0", stat_zero_cnt, stat_total_cnt); end
`endif
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hE000_0001 + k, 1'b1, 4'b1100, 5'(25 + k));
            step();
        end
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd25) begin errors++;
            $display("FAIL arst_pre got=v%b rd%0d exp=v1 rd25", out_valid, out_rd); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL arst_ctrl got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        checks++; if ({out_result, out_zero, out_op, out_rd} !== 42'h0 || {stat_zero_cnt, stat_total_cnt} !== 32'h0) begin errors++;
            $display("FAIL arst_fields got=%h/%b/%h/%0d st=%h/%h exp=0", out_result, out_zero, out_op, out_rd, stat_zero_cnt, stat_total_cnt); end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_stats();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
